// File: rtl/rep_pol_comb_pkg.sv
// Shared definitions for the 4-way replacement-policy decoder.
package rep_pol_comb_pkg;

    localparam int NUM_WAYS  = 4;
    localparam int WAY_IDX_W = 2;

    typedef logic [WAY_IDX_W-1:0] way_idx_t;

endpackage

// File: rtl/rep_pol_comb_comparator.sv
// Unsigned comparator node: equality when op=0, strict less-than when op=1.
module comparator #(
    parameter int INPUT_SIZE = 32
) (
    input  logic                  op,
    input  logic [INPUT_SIZE-1:0] in_1,
    input  logic [INPUT_SIZE-1:0] in_2,
    output logic                  comp_out
);

    // Operands are plain unsigned vectors, so no sign extension can creep in.
    always_comb begin
        comp_out = 1'b0;
        if (op) begin
            comp_out = (in_1 < in_2);
        end else begin
            comp_out = (in_1 == in_2);
        end
    end

endmodule

// File: rtl/rep_pol_comb.sv
// Victim selection for a 4-way set: picks the way with the smallest unsigned
// age/usage word (lowest index on ties), plus a registered copy of the index.
module rep_pol_comb
    import rep_pol_comb_pkg::*;
#(
    parameter int LINE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_0,
    input  logic [LINE_W-1:0] line_1,
    input  logic [LINE_W-1:0] line_2,
    input  logic [LINE_W-1:0] line_3,
    input  logic              upd,
    output logic [1:0]        rplc,
    output logic [1:0]        rplc_q,
    output logic [LINE_W-1:0] min_val
);

    logic              lt_01;
    logic              lt_23;
    logic              lt_fin;
    way_idx_t          w01_idx;
    way_idx_t          w23_idx;
    logic [LINE_W-1:0] w01_val;
    logic [LINE_W-1:0] w23_val;

    // Each node asks "is the higher-index candidate strictly smaller?" so an
    // equal value always keeps the lower index.
    comparator #(.INPUT_SIZE(LINE_W)) u_cmp_01 (
        .op       (1'b1),
        .in_1     (line_1),
        .in_2     (line_0),
        .comp_out (lt_01)
    );

    comparator #(.INPUT_SIZE(LINE_W)) u_cmp_23 (
        .op       (1'b1),
        .in_1     (line_3),
        .in_2     (line_2),
        .comp_out (lt_23)
    );

    comparator #(.INPUT_SIZE(LINE_W)) u_cmp_fin (
        .op       (1'b1),
        .in_1     (w23_val),
        .in_2     (w01_val),
        .comp_out (lt_fin)
    );

    // First tree level: winner of each pair, index and value together.
    always_comb begin
        w01_idx = 2'd0;
        w01_val = line_0;
        if (lt_01) begin
            w01_idx = 2'd1;
            w01_val = line_1;
        end
        w23_idx = 2'd2;
        w23_val = line_2;
        if (lt_23) begin
            w23_idx = 2'd3;
            w23_val = line_3;
        end
    end

    // Second tree level: the upper pair only wins when strictly smaller.
    always_comb begin
        rplc    = w01_idx;
        min_val = w01_val;
        if (lt_fin) begin
            rplc    = w23_idx;
            min_val = w23_val;
        end
    end

    // Held copy of the victim index; loads only when upd is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rplc_q <= 2'd0;
        end else if (upd) begin
            rplc_q <= rplc;
        end
    end

endmodule

// File: tb/tb_rep_pol_comb.sv
// Self-checking bench for rep_pol_comb: directed cases, register/reset
// behaviour and randomized vectors against a linear-scan reference.
module tb_rep_pol_comb;

    localparam int LINE_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [LINE_W-1:0] line_0 = '0;
    logic [LINE_W-1:0] line_1 = '0;
    logic [LINE_W-1:0] line_2 = '0;
    logic [LINE_W-1:0] line_3 = '0;
    logic              upd = 1'b0;
    logic [1:0]        rplc;
    logic [1:0]        rplc_q;
    logic [LINE_W-1:0] min_val;

    int checks = 0;
    int errors = 0;

    rep_pol_comb #(.LINE_W(LINE_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .line_0  (line_0),
        .line_1  (line_1),
        .line_2  (line_2),
        .line_3  (line_3),
        .upd     (upd),
        .rplc    (rplc),
        .rplc_q  (rplc_q),
        .min_val (min_val)
    );

    always #5 clk = ~clk;

    // Reference: first index holding the minimum, by a plain linear scan.
    function automatic logic [1:0] ref_idx(input logic [LINE_W-1:0] a, input logic [LINE_W-1:0] b,
                                           input logic [LINE_W-1:0] c, input logic [LINE_W-1:0] d);
        logic [LINE_W-1:0] v [4];
        int best;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (v[i] < v[best]) best = i;
        end
        return best[1:0];
    endfunction

    function automatic logic [LINE_W-1:0] ref_min(input logic [LINE_W-1:0] a, input logic [LINE_W-1:0] b,
                                                  input logic [LINE_W-1:0] c, input logic [LINE_W-1:0] d);
        logic [LINE_W-1:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    function automatic logic [LINE_W-1:0] rand_val();
        logic [LINE_W-1:0] r;
        case ($urandom_range(0, 3))
            0: r = $urandom;
            1: r = LINE_W'($urandom_range(0, 3));
            2: begin
                case ($urandom_range(0, 3))
                    0: r = 32'h0000_0000;
                    1: r = 32'hFFFF_FFFF;
                    2: r = 32'h8000_0000;
                    default: r = 32'h7FFF_FFFF;
                endcase
            end
            default: r = 32'h8000_0000 | LINE_W'($urandom_range(0, 2));
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        upd = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rplc_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_async rplc_q=%0d expected=0", rplc_q);
        end
        // Edge with upd high while rst held: must stay cleared.
        line_0 = 32'd9; line_1 = 32'd9; line_2 = 32'd9; line_3 = 32'd1;
        @(posedge clk); #1;
        checks++;
        if (rplc_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold rplc_q=%0d expected=0", rplc_q);
        end
        @(negedge clk);
        rst = 1'b0;
        upd = 1'b0;
    endtask

    task automatic test_directed();
        logic [LINE_W-1:0] tv [7][4];
        logic [1:0]        ei [7];
        logic [LINE_W-1:0] em [7];
        tv[0] = '{32'd3, 32'd5, 32'd8, 32'd2};          ei[0] = 2'd3; em[0] = 32'd2;
        tv[1] = '{32'd3, 32'd5, 32'd8, 32'd3};          ei[1] = 2'd0; em[1] = 32'd3;
        tv[2] = '{32'd6, 32'd5, 32'd8, 32'd3};          ei[2] = 2'd3; em[2] = 32'd3;
        tv[3] = '{32'd6, 32'd5, 32'd8, 32'd7};          ei[3] = 2'd1; em[3] = 32'd5;
        tv[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ei[4] = 2'd0; em[4] = 32'hFFFF_FFFF;
        tv[5] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'h8000_0000};
        ei[5] = 2'd2; em[5] = 32'd0;
        tv[6] = '{32'd9, 32'd9, 32'd4, 32'd4};          ei[6] = 2'd2; em[6] = 32'd4;
        upd = 1'b0;
        for (int i = 0; i < 7; i++) begin
            line_0 = tv[i][0]; line_1 = tv[i][1]; line_2 = tv[i][2]; line_3 = tv[i][3];
            #1;
            checks++;
            if (rplc !== ei[i]) begin
                errors++;
                $display("FAIL directed_%0d_rplc actual=%0d expected=%0d", i, rplc, ei[i]);
            end
            checks++;
            if (min_val !== em[i]) begin
                errors++;
                $display("FAIL directed_%0d_min_val actual=%h expected=%h", i, min_val, em[i]);
            end
        end
        // All-zero: lowest index.
        line_0 = '0; line_1 = '0; line_2 = '0; line_3 = '0;
        #1;
        checks++;
        if (rplc !== 2'd0) begin
            errors++;
            $display("FAIL all_zero_rplc actual=%0d expected=0", rplc);
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        line_0 = 32'd3; line_1 = 32'd5; line_2 = 32'd8; line_3 = 32'd2;
        upd = 1'b1;
        @(posedge clk); #1;
        upd = 1'b0;
        checks++;
        if (rplc_q !== 2'd3) begin
            errors++;
            $display("FAIL reg_capture rplc_q=%0d expected=3", rplc_q);
        end
        // Inputs move with upd low: register must hold.
        @(negedge clk);
        line_0 = 32'd1; line_1 = 32'd5; line_2 = 32'd8; line_3 = 32'd2;
        @(posedge clk); #1;
        checks++;
        if (rplc_q !== 2'd3) begin
            errors++;
            $display("FAIL reg_hold rplc_q=%0d expected=3", rplc_q);
        end
        // Asynchronous clear between edges; combinational path untouched.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rplc_q !== 2'd0) begin
            errors++;
            $display("FAIL reg_async_clear rplc_q=%0d expected=0", rplc_q);
        end
        checks++;
        if (rplc !== 2'd0 || min_val !== 32'd1) begin
            errors++;
            $display("FAIL reset_comb_unaffected rplc=%0d min_val=%0d expected rplc=0 min_val=1", rplc, min_val);
        end
        @(negedge clk);
        rst = 1'b0;
        line_0 = 32'd7; line_1 = 32'd6; line_2 = 32'd8; line_3 = 32'd9;
        upd = 1'b1;
        @(posedge clk); #1;
        upd = 1'b0;
        checks++;
        if (rplc_q !== 2'd1) begin
            errors++;
            $display("FAIL reg_first_capture rplc_q=%0d expected=1", rplc_q);
        end
    endtask

    task automatic test_random();
        logic [1:0]        exp_q;
        logic [1:0]        exp_i;
        logic [LINE_W-1:0] exp_m;
        exp_q = rplc_q === 2'd1 ? 2'd1 : 2'd1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            line_0 = rand_val(); line_1 = rand_val(); line_2 = rand_val(); line_3 = rand_val();
            upd = ($urandom_range(0, 1) == 1);
            exp_i = ref_idx(line_0, line_1, line_2, line_3);
            exp_m = ref_min(line_0, line_1, line_2, line_3);
            #1;
            checks++;
            if (rplc !== exp_i || min_val !== exp_m) begin
                errors++;
                $display("FAIL random_%0d_comb rplc=%0d min_val=%h expected rplc=%0d min_val=%h",
                         n, rplc, min_val, exp_i, exp_m);
            end
            if (upd) exp_q = exp_i;
            @(posedge clk); #1;
            checks++;
            if (rplc_q !== exp_q) begin
                errors++;
                $display("FAIL random_%0d_reg rplc_q=%0d expected=%0d", n, rplc_q, exp_q);
            end
        end
        upd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_register();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rep_pol_comb.md
# rep_pol_comb

Cache replacement-policy decoder for a 4-way set. Each way supplies a 32-bit age/usage word; the block selects the way holding the smallest unsigned value as the victim. The selection is purely combinational. A registered copy is also provided for pipelines that need the victim index held across cycles. The block sits between the per-way tag/age arrays and the cache fill controller.

## Interface
- `LINE_W`, default 32: width of each line value; unsigned.
- `clk`  input  1  system clock; only the registered copy uses it.
- `rst`  input  1  asynchronous, active-high reset.
- `line_0`  input  LINE_W  value of way 0.
- `line_1`  input  LINE_W  value of way 1.
- `line_2`  input  LINE_W  value of way 2.
- `line_3`  input  LINE_W  value of way 3.
- `upd`  input  1  when high at a `clk` rising edge, `rplc_q` captures `rplc`.
- `rplc`  output  2  combinational victim index (0..3).
- `rplc_q`  output  2  registered victim index.
- `min_val`  output  LINE_W  combinational value of the selected way.

## Operation
- All comparisons are unsigned, full LINE_W width; no sign extension.
- `rplc` is the index of the minimum of `line_0..line_3`.
- Tie rule: among equal minima, the lowest index wins.
- Selection is a two-level tree:
  - Stage A: `w01` = way 1 if `line_1 < line_0`, else way 0.
  - Stage A: `w23` = way 3 if `line_3 < line_2`, else way 2.
  - Stage B: pick `w23` only if its value is strictly less than `w01`'s value; otherwise pick `w01`.
  - The strict less-than at every node is what produces the lowest-index tie rule.
- `min_val` equals the `line_x` selected by `rplc`.
- All-equal inputs, including all-zero and all-ones, give `rplc = 0`.
- `rplc_q`:
  - On a `clk` rising edge with `upd = 1`, load `rplc`.
  - With `upd = 0`, hold.
- No other state exists.

## Timing
- `rplc` and `min_val` have zero-cycle latency: pure combinational, settle within the same delta as the input change. There is no clock dependence.
- `rplc_q` has one-cycle latency: it reflects `rplc` sampled at the edge where `upd` is high.
- Reset:
  - `rst` high clears `rplc_q` to 0 immediately, without waiting for a clock edge.
  - Clearing holds while `rst` is high.
  - The first capture is the first rising edge after `rst` deasserts with `upd` high.
- `rst` asserted mid-operation clears `rplc_q` and does not affect `rplc` or `min_val`.
- Input changes while `upd = 0` never affect `rplc_q`.

## Structure
- A shared package holds:
  - `NUM_WAYS = 4`
  - `WAY_IDX_W = 2`
  - typedef `way_idx_t` (`logic [1:0]`)
- One sub-module is natural: `comparator` with parameter `INPUT_SIZE`.
  - Ports: `op`, `in_1`, `in_2`, `comp_out`.
  - `op = 0`: `comp_out = (in_1 == in_2)`.
  - `op = 1`: `comp_out = (in_1 < in_2)`, unsigned.
  - Instantiate three copies with `op` tied to 1, one per tree node.
- Top level: the three comparators, the index/value muxes, and the `rplc_q` register.

## Test plan
- Unique minimum: `line_0..3` = 3, 5, 8, 2 → `rplc = 3`, `min_val = 2`.
- Tie across halves: `line_0..3` = 3, 5, 8, 3 → `rplc = 0` (lowest index wins).
- Minimum moves as inputs change:
  - Change to 6, 5, 8, 3 → `rplc = 3`.
  - Then set `line_3 = 7` → `rplc = 1`, `min_val = 5`.
- Extremes and full-width unsigned:
  - All inputs `32'hFFFF_FFFF` → `rplc = 0`.
  - `line_2 = 0`, others `32'h8000_0000` → `rplc = 2`, proving no signed compare.
  - Ties within a pair, e.g. 9, 9, 4, 4 → `rplc = 2`.
- Register and reset:
  - Apply 3, 5, 8, 2 with `upd = 1` for one edge → `rplc_q = 3` after the edge.
  - Change inputs with `upd = 0` → `rplc_q` stays 3.
  - Assert `rst` between edges → `rplc_q = 0` immediately while `rplc` is unaffected.
- Randomized check, 1000 vectors: `rplc` equals a reference that returns the first index of the minimum.
